// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/forwarding controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LU_BUBBLE = 2'd1,
        MEM_WAIT  = 2'd2,
        FLUSH     = 2'd3
    } state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0
    localparam int unsigned REG_ZERO  = 0;

endpackage

// File: rtl/fwd_mux.sv
// Per-operand forwarding selector: the youngest qualified producer wins,
// a load sitting in stage 0 is never a forwarding source.
module fwd_mux
    import hazard_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR   = 5,
    parameter int FWD_STAGES = 2
) (
    input  logic [REG_ADDR-1:0]            rs,
    input  logic                           use_rs,
    input  logic [DATA_WIDTH-1:0]          op,
    input  logic [FWD_STAGES-1:0]          stg_valid,
    input  logic [FWD_STAGES-1:0]          stg_reg_write,
    input  logic                           load0,
    input  logic [FWD_STAGES*REG_ADDR-1:0] stg_rd,
    input  logic [FWD_STAGES*DATA_WIDTH-1:0] stg_data,
    output logic [DATA_WIDTH-1:0]          result
);

    // Walk oldest to youngest so a younger match overrides an older one.
    always_comb begin
        // NOTE: assigning a default before any conditional keeps this purely
        // combinational; a path that leaves result unassigned would infer a latch.
        result = op;
        for (int i = FWD_STAGES - 1; i >= 0; i--) begin
            if (use_rs && stg_valid[i] && stg_reg_write[i]
                && (stg_rd[i*REG_ADDR +: REG_ADDR] == rs)
                && (rs != REG_ADDR'(REG_ZERO))
                && !((i == 0) && load0)) begin
                result = stg_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard, forwarding and stall/flush controller for the RV32I pipeline:
// operand forwarding, load-use bubbles, memory-wait stalls and redirect flushes.
module hazard_fwd_unit
    import hazard_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int REG_ADDR     = 5,
    parameter int FWD_STAGES   = 2,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [REG_ADDR-1:0]              ex_rs1,
    input  logic [REG_ADDR-1:0]              ex_rs2,
    input  logic                             ex_use_rs1,
    input  logic                             ex_use_rs2,
    input  logic [DATA_WIDTH-1:0]            ex_op_a,
    input  logic [DATA_WIDTH-1:0]            ex_op_b,
    input  logic [FWD_STAGES-1:0]            stg_valid,
    input  logic [FWD_STAGES-1:0]            stg_reg_write,
    input  logic [FWD_STAGES-1:0]            stg_is_load,
    input  logic [FWD_STAGES*REG_ADDR-1:0]   stg_rd,
    input  logic [FWD_STAGES*DATA_WIDTH-1:0] stg_data,
    input  logic                             mem_load_req,
    input  logic                             dm_valid,
    input  logic                             redirect,
    output logic [DATA_WIDTH-1:0]            alu_a,
    output logic [DATA_WIDTH-1:0]            alu_b,
    output logic                             stall_fd,
    output logic                             bubble_ex,
    output logic                             stall_all,
    output logic                             flush_fd,
    output logic [CNT_WIDTH-1:0]             stall_cnt,
    output logic [CNT_WIDTH-1:0]             flush_cnt
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    state_t        state, next_state;
    logic          pending, pending_next;
    logic [2:0]    flush_ctr, flush_ctr_next;
    logic          flush_accept;
    logic          lu_hazard;
    logic          mem_wait_start;
    logic [REG_ADDR-1:0] rd0;
    logic          unused_load_bits;

    fwd_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_ADDR   (REG_ADDR),
        .FWD_STAGES (FWD_STAGES)
    ) u_fwd_a (
        .rs            (ex_rs1),
        .use_rs        (ex_use_rs1),
        .op            (ex_op_a),
        .stg_valid     (stg_valid),
        .stg_reg_write (stg_reg_write),
        .load0         (stg_is_load[0]),
        .stg_rd        (stg_rd),
        .stg_data      (stg_data),
        .result        (alu_a)
    );

    fwd_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_ADDR   (REG_ADDR),
        .FWD_STAGES (FWD_STAGES)
    ) u_fwd_b (
        .rs            (ex_rs2),
        .use_rs        (ex_use_rs2),
        .op            (ex_op_b),
        .stg_valid     (stg_valid),
        .stg_reg_write (stg_reg_write),
        .load0         (stg_is_load[0]),
        .stg_rd        (stg_rd),
        .stg_data      (stg_data),
        .result        (alu_b)
    );

    // Only the youngest stage's load flag creates a load-use hazard.
    assign unused_load_bits = ^stg_is_load;

    assign rd0            = stg_rd[REG_ADDR-1:0];
    assign mem_wait_start = mem_load_req && !dm_valid;
    assign lu_hazard      = stg_valid[0] && stg_reg_write[0] && stg_is_load[0]
                            && (rd0 != REG_ADDR'(REG_ZERO))
                            && ((ex_use_rs1 && (rd0 == ex_rs1))
                             || (ex_use_rs2 && (rd0 == ex_rs2)));

    always_comb begin
        next_state     = state;
        pending_next   = pending;
        flush_ctr_next = flush_ctr;
        flush_accept   = 1'b0;
        stall_fd       = 1'b0;
        bubble_ex      = 1'b0;
        stall_all      = 1'b0;
        flush_fd       = 1'b0;

        unique case (state)
            RUN, LU_BUBBLE: begin
                // LU_BUBBLE still honours memory waits and redirects; only the
                // load-use check is skipped since stage 0 now holds the bubble.
                if (mem_wait_start) begin
                    stall_all    = 1'b1;
                    stall_fd     = 1'b1;
                    pending_next = redirect;
                    next_state   = MEM_WAIT;
                end else if (redirect) begin
                    flush_accept   = 1'b1;
                    flush_ctr_next = FLUSH_LOAD;
                    next_state     = FLUSH;
                end else if ((state == RUN) && lu_hazard) begin
                    stall_fd   = 1'b1;
                    bubble_ex  = 1'b1;
                    next_state = LU_BUBBLE;
                end else begin
                    next_state = RUN;
                end
            end

            MEM_WAIT: begin
                if (!dm_valid) begin
                    stall_all = 1'b1;
                    stall_fd  = 1'b1;
                    if (redirect) begin
                        pending_next = 1'b1;
                    end
                end else begin
                    pending_next = 1'b0;
                    if (pending || redirect) begin
                        flush_accept   = 1'b1;
                        flush_ctr_next = FLUSH_LOAD;
                        next_state     = FLUSH;
                    end else begin
                        next_state = RUN;
                    end
                end
            end

            FLUSH: begin
                flush_fd  = 1'b1;
                // A memory stall during the flush freezes the flush count too.
                stall_all = mem_wait_start;
                stall_fd  = mem_wait_start;
                if (redirect) begin
                    flush_accept   = 1'b1;
                    flush_ctr_next = FLUSH_LOAD;
                end else if (mem_wait_start) begin
                    flush_ctr_next = flush_ctr;
                end else if (flush_ctr == 3'd0) begin
                    next_state = RUN;
                end else begin
                    flush_ctr_next = flush_ctr - 3'd1;
                end
            end

            default: next_state = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            pending   <= 1'b0;
            flush_ctr <= 3'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state     <= next_state;
            pending   <= pending_next;
            flush_ctr <= flush_ctr_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if ((stall_fd || stall_all) && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (flush_accept && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit: forwarding, load-use, memory wait,
// pending redirect, counter saturation and asynchronous reset.
module tb_hazard_fwd_unit;
    import hazard_pkg::*;

    localparam int DW = 32;
    localparam int RA = 5;
    localparam int FS = 2;
    localparam int FC = 2;
    localparam int CW = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [RA-1:0]     ex_rs1, ex_rs2;
    logic              ex_use_rs1, ex_use_rs2;
    logic [DW-1:0]     ex_op_a, ex_op_b;
    logic [FS-1:0]     stg_valid, stg_reg_write, stg_is_load;
    logic [FS*RA-1:0]  stg_rd;
    logic [FS*DW-1:0]  stg_data;
    logic              mem_load_req, dm_valid, redirect;
    logic [DW-1:0]     alu_a, alu_b;
    logic              stall_fd, bubble_ex, stall_all, flush_fd;
    logic [CW-1:0]     stall_cnt, flush_cnt;

    int total = 0;
    int bad   = 0;

    hazard_fwd_unit #(
        .DATA_WIDTH   (DW),
        .REG_ADDR     (RA),
        .FWD_STAGES   (FS),
        .FLUSH_CYCLES (FC),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_rs1        (ex_rs1),
        .ex_rs2        (ex_rs2),
        .ex_use_rs1    (ex_use_rs1),
        .ex_use_rs2    (ex_use_rs2),
        .ex_op_a       (ex_op_a),
        .ex_op_b       (ex_op_b),
        .stg_valid     (stg_valid),
        .stg_reg_write (stg_reg_write),
        .stg_is_load   (stg_is_load),
        .stg_rd        (stg_rd),
        .stg_data      (stg_data),
        .mem_load_req  (mem_load_req),
        .dm_valid      (dm_valid),
        .redirect      (redirect),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .stall_fd      (stall_fd),
        .bubble_ex     (bubble_ex),
        .stall_all     (stall_all),
        .flush_fd      (flush_fd),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_stage(input int idx, input logic v, input logic w, input logic ld,
                             input logic [RA-1:0] rd, input logic [DW-1:0] d);
        stg_valid[idx]         = v;
        stg_reg_write[idx]     = w;
        stg_is_load[idx]       = ld;
        stg_rd[idx*RA +: RA]   = rd;
        stg_data[idx*DW +: DW] = d;
    endtask

    task automatic idle();
        stg_valid     = '0;
        stg_reg_write = '0;
        stg_is_load   = '0;
        stg_rd        = '0;
        stg_data      = '0;
        mem_load_req  = 1'b0;
        dm_valid      = 1'b0;
        redirect      = 1'b0;
        ex_use_rs1    = 1'b0;
        ex_use_rs2    = 1'b0;
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 2 units later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst     = 1'b1;
        ex_rs1  = '0;
        ex_rs2  = '0;
        ex_op_a = 32'h1111_0000;
        ex_op_b = 32'h2222_0000;
        idle();
        #3;
        check("rst_alu_a", alu_a, 32'h1111_0000);
        check("rst_alu_b", alu_b, 32'h2222_0000);
        check("rst_stall_fd", stall_fd, 0);
        check("rst_bubble", bubble_ex, 0);
        check("rst_stall_all", stall_all, 0);
        check("rst_flush_fd", flush_fd, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_flush_cnt", flush_cnt, 0);
        step(); rst = 1'b0;

        // Forwarding from stage 0, stage 1, both
        step(); set_stage(0, 1, 1, 0, 5'd5, 32'd7);
        ex_rs1 = 5'd5; ex_use_rs1 = 1'b1; ex_op_a = 32'd0; #2;
        check("fwd_s0", alu_a, 32'd7);
        check("fwd_s0_no_stall", stall_fd, 0);
        step(); set_stage(0, 0, 0, 0, 5'd0, 32'd0); set_stage(1, 1, 1, 0, 5'd5, 32'd9); #2;
        check("fwd_s1", alu_a, 32'd9);
        step(); set_stage(0, 1, 1, 0, 5'd5, 32'd7);
        ex_rs2 = 5'd5; ex_use_rs2 = 1'b0; ex_op_b = 32'hB; #2;
        check("fwd_youngest", alu_a, 32'd7);
        check("fwd_use_rs2_off", alu_b, 32'hB);
        // x0, write-enable and valid qualification
        step(); idle(); set_stage(0, 1, 1, 0, 5'd0, 32'd5);
        ex_rs1 = 5'd0; ex_use_rs1 = 1'b1; ex_op_a = 32'h1234; #2;
        check("fwd_x0", alu_a, 32'h1234);
        step(); set_stage(0, 1, 0, 0, 5'd5, 32'd5); ex_rs1 = 5'd5; #2;
        check("fwd_no_write", alu_a, 32'h1234);
        step(); set_stage(0, 0, 1, 0, 5'd5, 32'd5); #2;
        check("fwd_not_valid", alu_a, 32'h1234);
        // Independent operands from different stages
        step(); set_stage(0, 1, 1, 0, 5'd5, 32'd7); set_stage(1, 1, 1, 0, 5'd6, 32'h66);
        ex_rs2 = 5'd6; ex_use_rs2 = 1'b1; #2;
        check("fwd_a_s0", alu_a, 32'd7);
        check("fwd_b_s1", alu_b, 32'h66);
        check("no_stall_yet", stall_cnt, 0);

        // Load-use: one bubble, then stage 1 supplies the load data
        step(); idle(); set_stage(0, 1, 1, 1, 5'd6, 32'hDEAD);
        ex_rs2 = 5'd6; ex_use_rs2 = 1'b1; ex_op_b = 32'h11; #2;
        check("lu_bubble", bubble_ex, 1);
        check("lu_stall_fd", stall_fd, 1);
        check("lu_stall_all", stall_all, 0);
        check("lu_no_fwd_load", alu_b, 32'h11);
        step(); set_stage(0, 0, 0, 0, 5'd0, 32'd0); set_stage(1, 1, 1, 1, 5'd6, 32'h55); #2;
        check("lu_fwd_s1", alu_b, 32'h55);
        check("lu_bubble_off", bubble_ex, 0);
        check("lu_stall_off", stall_fd, 0);
        check("lu_stall_cnt", stall_cnt, 1);
        step(); idle(); #2;
        check("lu_idle_cnt", stall_cnt, 1);
        check("lu_idle_bubble", bubble_ex, 0);
        // Load in stage 0 skipped, older stage 1 still forwards
        step(); set_stage(0, 1, 1, 1, 5'd6, 32'hDEAD); set_stage(1, 1, 1, 0, 5'd6, 32'h77);
        ex_rs2 = 5'd6; ex_use_rs2 = 1'b1; #2;
        check("lu_skip_s0", alu_b, 32'h77);
        check("lu_skip_bubble", bubble_ex, 1);
        step(); idle(); #2;
        check("lu_skip_cnt", stall_cnt, 2);

        rst = 1'b1;
        step(); rst = 1'b0;

        // Memory wait: three cycles without dm_valid
        step(); mem_load_req = 1'b1; dm_valid = 1'b0; #2;
        check("mw_c0_stall_all", stall_all, 1);
        check("mw_c0_stall_fd", stall_fd, 1);
        step(); #2;
        check("mw_c1_stall_all", stall_all, 1);
        step(); #2;
        check("mw_c2_stall_all", stall_all, 1);
        step(); dm_valid = 1'b1; #2;
        check("mw_dv_stall_all", stall_all, 0);
        check("mw_dv_stall_fd", stall_fd, 0);
        check("mw_stall_cnt", stall_cnt, 3);
        step(); idle(); #2;
        check("mw_after_cnt", stall_cnt, 3);

        // Redirect while waiting on memory is held until dm_valid
        step(); mem_load_req = 1'b1; dm_valid = 1'b0; #2;
        check("rmw_c0_stall_all", stall_all, 1);
        step(); redirect = 1'b1; #2;
        check("rmw_c1_flush", flush_fd, 0);
        step(); redirect = 1'b0; #2;
        check("rmw_c2_flush", flush_fd, 0);
        step(); dm_valid = 1'b1; #2;
        check("rmw_dv_flush", flush_fd, 0);
        check("rmw_dv_stall_all", stall_all, 0);
        step(); idle(); #2;
        check("rmw_f1", flush_fd, 1);
        check("rmw_flush_cnt", flush_cnt, 1);
        step(); #2;
        check("rmw_f2", flush_fd, 1);
        step(); #2;
        check("rmw_f_end", flush_fd, 0);
        check("rmw_flush_cnt_end", flush_cnt, 1);
        check("rmw_stall_cnt", stall_cnt, 6);

        // Saturation of the stall counter (6 + 12 > 15)
        for (int i = 0; i < 12; i++) begin
            step(); mem_load_req = 1'b1; dm_valid = 1'b0;
        end
        step(); dm_valid = 1'b1; #2;
        check("sat_stall_cnt", stall_cnt, 15);
        step(); idle(); #2;
        check("sat_hold", stall_cnt, 15);

        // Reset asserted asynchronously during the first flush cycle
        step(); redirect = 1'b1; #2;
        check("rf_redirect_cycle", flush_fd, 0);
        step(); redirect = 1'b0; #2;
        check("rf_f1", flush_fd, 1);
        check("rf_flush_cnt", flush_cnt, 2);
        #1 rst = 1'b1;
        #1;
        check("rf_async_flush", flush_fd, 0);
        check("rf_async_flush_cnt", flush_cnt, 0);
        check("rf_async_stall_cnt", stall_cnt, 0);
        step(); rst = 1'b0;
        step(); set_stage(0, 1, 1, 1, 5'd7, 32'd0);
        ex_rs1 = 5'd7; ex_use_rs1 = 1'b1; #2;
        check("rf_run_bubble", bubble_ex, 1);
        check("rf_run_flush", flush_fd, 0);
        step(); idle(); #2;

        // Redirect inside FLUSH reloads the count
        step(); redirect = 1'b1; #2;
        step(); #2;
        check("rl_f1", flush_fd, 1);
        step(); redirect = 1'b0; #2;
        check("rl_f2", flush_fd, 1);
        step(); #2;
        check("rl_f3", flush_fd, 1);
        step(); #2;
        check("rl_end", flush_fd, 0);
        check("rl_flush_cnt", flush_cnt, 2);
        check("nop_const", NOP_INSTR, 32'h0000_0013);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
- Centralised hazard, forwarding and stall/flush controller for the pipelined RV32I core.
- Replaces the single-stage rs==rd forwarding mux in front of the ALU with these additions:
  - parametrised multi-stage forwarding qualified by write-enable and valid, with x0 excluded;
  - load-use bubble insertion;
  - a stall that waits for variable-latency data memory via the dm_valid handshake;
  - a counted flush on control-flow redirect.
- Sits beside decode/execute; drives ALU operands and pipeline-register enables/flushes.

Parameters:
DATA_WIDTH, 32, operand/result width
REG_ADDR, 5, register index width
FWD_STAGES, 2, number of producer stages able to forward (index 0 = youngest, i.e. EX/MEM)
FLUSH_CYCLES, 2, number of cycles flush_fd is held after a redirect (1..7)
CNT_WIDTH, 16, width of performance counters

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
ex_rs1  in  REG_ADDR  rs1 of instruction in the decode/execute register
ex_rs2  in  REG_ADDR  rs2 of instruction in the decode/execute register
ex_use_rs1  in  1  instruction reads rs1 (register operand selected)
ex_use_rs2  in  1  instruction reads rs2
ex_op_a  in  DATA_WIDTH  operand A from decode pipe
ex_op_b  in  DATA_WIDTH  operand B from decode pipe
stg_valid  in  FWD_STAGES  producer stage holds a valid instruction
stg_reg_write  in  FWD_STAGES  producer writes rd
stg_is_load  in  FWD_STAGES  producer is a load
stg_rd  in  FWD_STAGES*REG_ADDR  producer rd, stage i at [i*REG_ADDR +: REG_ADDR]
stg_data  in  FWD_STAGES*DATA_WIDTH  producer result, same packing
mem_load_req  in  1  memory stage issuing a load this cycle
dm_valid  in  1  data memory response valid
redirect  in  1  branch taken / jal / jalr resolved in execute
alu_a  out  DATA_WIDTH  forwarded operand A
alu_b  out  DATA_WIDTH  forwarded operand B
stall_fd  out  1  hold PC and fetch/decode register
bubble_ex  out  1  load a NOP into the decode/execute register
stall_all  out  1  freeze every pipeline register (memory wait)
flush_fd  out  1  squash fetch/decode register
stall_cnt  out  CNT_WIDTH  saturating count of stall cycles
flush_cnt  out  CNT_WIDTH  saturating count of redirects

Behaviour:
- Forwarding (combinational):
  - For each operand, the youngest stage i satisfying stg_valid & stg_reg_write & rd==rs & rd!=0 & use_rs supplies stg_data[i]; otherwise ex_op passes through.
  - A matching producer with stg_is_load[0] set never forwards from stage 0. Its load-use hazard is handled by the FSM.
- FSM states: RUN, LU_BUBBLE, MEM_WAIT, FLUSH.
  - RUN: if mem_load_req & !dm_valid -> MEM_WAIT. Else if redirect -> FLUSH. Else if a load-use hazard exists -> LU_BUBBLE.
  - LU_BUBBLE (one cycle): stall_fd=1, bubble_ex=1, then -> RUN. A load-use hazard is detected in RUN, but the outputs are asserted combinationally in that same cycle (Mealy), so the consumer sees data from stage 1 on the next cycle.
  - MEM_WAIT: stall_all=1 and stall_fd=1 until dm_valid. On the dm_valid cycle stall_all deasserts, then -> RUN.
  - FLUSH: flush_fd=1 for FLUSH_CYCLES cycles, counted by a down-counter loaded with FLUSH_CYCLES-1 on entry; -> RUN at zero.
- Priority on simultaneous events:
  - memory wait > redirect > load-use.
  - A redirect arriving during MEM_WAIT is latched in a pending bit and serviced (-> FLUSH) on the dm_valid cycle.
  - A redirect arriving during FLUSH reloads the counter.
  - A load-use hazard during FLUSH is ignored, because the consumer is being squashed.
- Counters:
  - stall_cnt increments on each cycle with stall_fd|stall_all.
  - flush_cnt increments on each accepted redirect.
  - Both saturate at all-ones.
- Reset (async, rst high): state=RUN, pending redirect=0, flush counter=0, stall_cnt=0, flush_cnt=0. Therefore stall_fd=bubble_ex=stall_all=flush_fd=0.
  - alu_a/alu_b remain combinational; during reset, stage inputs are expected invalid, so they equal ex_op_a/ex_op_b.
  - Reset mid-MEM_WAIT abandons the outstanding load.

Decomposition:
- Shared package hazard_pkg: state enum typedef (RUN, LU_BUBBLE, MEM_WAIT, FLUSH), the NOP instruction constant 32'h00000013, and REG_ZERO=0.
- One natural sub-module, fwd_mux: a per-operand youngest-match priority selector, instantiated twice.

Test Plan:
- Back-to-back forward: addi x5=7 in stage0 (valid, write), ex_rs1=5, ex_op_a=0 -> alu_a=7. Same match in stage1 only, stg_data=9 -> alu_a=9. Both stages match -> stage0 value.
- x0 and write-enable qualify: stage0 rd=0 data=5, ex_rs1=0 -> alu_a=ex_op_a. With rd=5 and reg_write=0 -> no forward.
- Load-use: stage0 is_load rd=6, ex_rs2=6 -> bubble_ex=1 and stall_fd=1 for exactly one cycle. Next cycle stage1 data=0x55 -> alu_b=0x55, stall_cnt=1.
- Memory wait: mem_load_req=1 with dm_valid low for 3 cycles -> stall_all=1 for 3 cycles, dropping on the dm_valid cycle, stall_cnt=3.
- Redirect during MEM_WAIT: redirect pulse at wait cycle 1 -> no flush until dm_valid. Then flush_fd=1 for FLUSH_CYCLES=2 cycles, flush_cnt=1.
- Reset mid-FLUSH: assert rst asynchronously in the 1st flush cycle -> flush_fd=0 immediately, counters are 0, and the FSM resumes in RUN after release.
